// File: rtl/fenotipo_pkg.sv
// Shared parameter set, derived widths, node indexing and FSM states for the phenotype evaluators.
package fenotipo_pkg;

    localparam int unsigned IN        = 4;
    localparam int unsigned OUT       = 2;
    localparam int unsigned ROW       = 4;
    localparam int unsigned COL       = 4;
    localparam int unsigned K         = 4;

    localparam int unsigned TT        = 2 ** K;
    localparam int unsigned NODES     = IN + ROW * COL;
    localparam int unsigned BITS_ELEM = $clog2(NODES);
    localparam int unsigned BITS_MAT  = TT * ROW * COL;
    localparam int unsigned CROM_W    = BITS_MAT + BITS_ELEM * OUT;
    localparam int unsigned NVEC      = 2 ** IN;
    localparam int unsigned TGT_W     = OUT * NVEC;
    localparam int unsigned FIT_W     = $clog2(OUT * NVEC + 1);
    localparam int unsigned COL_W     = (COL > 1) ? $clog2(COL) : 1;
    localparam int unsigned VEC_W     = IN;

    // Global node index of LUT (r,c); primary inputs occupy 0..IN-1.
    function automatic int unsigned node_index(input int unsigned c, input int unsigned r);
        return IN + c * ROW + r;
    endfunction

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        CMP  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/fenotipo_fitness_serial_lut_column.sv
// One column of ROW K-input LUTs; purely combinational.
module fenotipo_fitness_serial_lut_column
    import fenotipo_pkg::*;
(
    input  logic [ROW*TT-1:0] i_desc,
    input  logic [ROW*K-1:0]  i_sel,
    output logic [ROW-1:0]    o_out_c
);

    // Each LUT output is its truth-table bit addressed by its K inputs.
    for (genvar r = 0; r < ROW; r++) begin : g_lut
        logic [TT-1:0] w_tt;
        logic [K-1:0]  w_addr;
        assign w_tt       = i_desc[r*TT +: TT];
        assign w_addr     = i_sel[r*K +: K];
        assign o_out_c[r] = w_tt[w_addr];
    end

endmodule

// File: rtl/fenotipo_fitness_serial.sv
// Serial fitness evaluator: sweeps every input vector through the LUT grid one column per cycle.
module fenotipo_fitness_serial
    import fenotipo_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CROM_W-1:0] cromossomo,
    input  logic [TGT_W-1:0]  target,
    output logic              busy,
    output logic              done,
    output logic [FIT_W-1:0]  fitness
);

    state_t              r_state, w_state_nxt;
    logic [CROM_W-1:0]   r_crom, w_crom_nxt;
    logic [TGT_W-1:0]    r_tgt, w_tgt_nxt;
    logic [VEC_W-1:0]    r_vec, w_vec_nxt;
    logic [COL_W-1:0]    r_col, w_col_nxt;
    logic [FIT_W-1:0]    r_acc, w_acc_nxt;
    logic [ROW*COL-1:0]  r_node, w_node_nxt;
    logic                r_busy, w_busy_nxt;
    logic                r_done, w_done_nxt;
    logic [FIT_W-1:0]    r_fitness, w_fit_nxt;

    logic [ROW*TT-1:0]   w_desc;
    logic [ROW*K-1:0]    w_lin;
    logic [ROW-1:0]      w_col_out;
    logic [NODES-1:0]    w_all;
    logic [FIT_W-1:0]    w_add;

    // Column mux: descriptors and LUT inputs for the column currently being evaluated.
    always_comb begin
        int c_prev;
        w_desc = '0;
        w_lin  = '0;
        c_prev = int'(r_col) - 1;
        for (int r = 0; r < ROW; r++) begin
            w_desc[r*TT +: TT] = r_crom[TT*(COL*r + int'(r_col)) +: TT];
            for (int t = 0; t < K; t++) begin
                if (r_col == '0) begin
                    w_lin[r*K + t] = r_vec[(r + t) % IN];
                end else begin
                    w_lin[r*K + t] = r_node[c_prev*ROW + ((r + t) % ROW)];
                end
            end
        end
    end

    fenotipo_fitness_serial_lut_column u_lut_column (
        .i_desc  (w_desc),
        .i_sel   (w_lin),
        .o_out_c (w_col_out)
    );

    // Output selection and match count for the current vector; out-of-range selectors read 0.
    always_comb begin
        logic [BITS_ELEM-1:0] sel;
        logic                 o;
        w_all = {r_node, r_vec};
        w_add = '0;
        for (int k = 0; k < OUT; k++) begin
            sel = r_crom[BITS_MAT + BITS_ELEM*k +: BITS_ELEM];
            o   = ({1'b0, sel} < (BITS_ELEM+1)'(NODES)) ? w_all[sel] : 1'b0;
            if (o == r_tgt[int'(r_vec)*OUT + k]) begin
                w_add = w_add + FIT_W'(1);
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state and datapath/output next values.
    always_comb begin
        w_state_nxt = r_state;
        w_crom_nxt  = r_crom;
        w_tgt_nxt   = r_tgt;
        w_vec_nxt   = r_vec;
        w_col_nxt   = r_col;
        w_acc_nxt   = r_acc;
        w_node_nxt  = r_node;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_fit_nxt   = r_fitness;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_crom_nxt  = cromossomo;
                    w_tgt_nxt   = target;
                    w_vec_nxt   = '0;
                    w_col_nxt   = '0;
                    w_acc_nxt   = '0;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = EVAL;
                end
            end
            EVAL: begin
                w_node_nxt[int'(r_col)*ROW +: ROW] = w_col_out;
                if (r_col == COL_W'(COL - 1)) w_state_nxt = CMP;
                else                          w_col_nxt   = r_col + COL_W'(1);
            end
            CMP: begin
                w_acc_nxt = r_acc + w_add;
                if (r_vec == VEC_W'(NVEC - 1)) begin
                    w_fit_nxt   = r_acc + w_add;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = DONE;
                end else begin
                    w_vec_nxt   = r_vec + VEC_W'(1);
                    w_col_nxt   = '0;
                    w_state_nxt = EVAL;
                end
            end
            DONE: begin
                w_busy_nxt  = 1'b0;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_crom    <= '0;
            r_tgt     <= '0;
            r_vec     <= '0;
            r_col     <= '0;
            r_acc     <= '0;
            r_node    <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_fitness <= '0;
        end else begin
            r_crom    <= w_crom_nxt;
            r_tgt     <= w_tgt_nxt;
            r_vec     <= w_vec_nxt;
            r_col     <= w_col_nxt;
            r_acc     <= w_acc_nxt;
            r_node    <= w_node_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_fitness <= w_fit_nxt;
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign fitness = r_fitness;

endmodule

// File: tb/tb_fenotipo_fitness_serial.sv
// Directed and randomized bench for fenotipo_fitness_serial with a vector-by-vector reference model.
module tb_fenotipo_fitness_serial;
    import fenotipo_pkg::*;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [CROM_W-1:0] cromossomo;
    logic [TGT_W-1:0]  target;
    logic              busy;
    logic              done;
    logic [FIT_W-1:0]  fitness;

    int checks   = 0;
    int failures = 0;

    fenotipo_fitness_serial dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .cromossomo (cromossomo),
        .target     (target),
        .busy       (busy),
        .done       (done),
        .fitness    (fitness)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Evaluate the evolved circuit for every input vector and count matching output bits.
    function automatic int model_fit(input logic [CROM_W-1:0] c, input logic [TGT_W-1:0] tg);
        int  fit;
        bit  val [NODES];
        int  idx, src, sel;
        bit  o;
        fit = 0;
        for (int v = 0; v < NVEC; v++) begin
            for (int i = 0; i < IN; i++) val[i] = bit'((v >> i) & 1);
            for (int cc = 0; cc < COL; cc++) begin
                for (int r = 0; r < ROW; r++) begin
                    idx = 0;
                    for (int t = 0; t < K; t++) begin
                        src = (cc == 0) ? (r + t) % IN : IN + (cc - 1) * ROW + (r + t) % ROW;
                        if (val[src]) idx = idx | (1 << t);
                    end
                    val[IN + cc*ROW + r] = c[TT*(COL*r + cc) + idx];
                end
            end
            for (int k = 0; k < OUT; k++) begin
                sel = int'(c[BITS_MAT + BITS_ELEM*k +: BITS_ELEM]);
                o   = (sel < NODES) ? val[sel] : 1'b0;
                if (o == tg[v*OUT + k]) fit++;
            end
        end
        return fit;
    endfunction

    function automatic logic [CROM_W-1:0] mk(input logic [TT-1:0] d,
                                             input logic [BITS_ELEM-1:0] s0,
                                             input logic [BITS_ELEM-1:0] s1);
        logic [CROM_W-1:0] x;
        x = '0;
        for (int i = 0; i < ROW*COL; i++) x[i*TT +: TT] = d;
        x[BITS_MAT +: BITS_ELEM]             = s0;
        x[BITS_MAT + BITS_ELEM +: BITS_ELEM] = s1;
        return x;
    endfunction

    // Start one evaluation; optionally inject an ignored start at cycle +10.
    task automatic run(input logic [CROM_W-1:0] c, input logic [TGT_W-1:0] tg,
                       input string tag, input int want, input bit inject,
                       input logic [CROM_W-1:0] c2);
        int n;
        int exp;
        logic [FIT_W-1:0] prev;
        exp  = model_fit(c, tg);
        prev = fitness;
        cromossomo = c;
        target     = tg;
        start      = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
            if (n == 1) begin
                start      = 1'b0;
                cromossomo = ~c;
                target     = ~tg;
                check({tag, "_busy"}, 32'(busy), 32'd1);
                check({tag, "_fit_hold"}, 32'(fitness), 32'(prev));
            end
            if (inject && n == 10) begin
                start      = 1'b1;
                cromossomo = c2;
            end
            if (inject && n == 11) start = 1'b0;
        end while (!done && n < 200);
        check({tag, "_latency"}, 32'(n), 32'd81);
        check({tag, "_fit_model"}, 32'(fitness), 32'(exp));
        if (want >= 0) check({tag, "_fit_const"}, 32'(fitness), 32'(want));
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        check({tag, "_busy_clr"}, 32'(busy), 32'd0);
    endtask

    initial begin
        logic [TGT_W-1:0]  t_id, t_const, t_sel, t_rnd;
        logic [CROM_W-1:0] c_id, c_ff, c_sel, c_rnd;
        int n;
        bit seen;

        rst_n = 1'b0; start = 1'b0; cromossomo = '0; target = '0;
        #15 rst_n = 1'b1;
        @(posedge clk); #1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_fit", 32'(fitness), 32'd0);

        for (int v = 0; v < NVEC; v++) begin
            t_id[v*2]      = v[0];
            t_id[v*2+1]    = v[1];
            t_const[v*2]   = 1'b1;
            t_const[v*2+1] = 1'b0;
            t_sel[v*2]     = 1'b0;
            t_sel[v*2+1]   = v[0];
        end
        c_id  = mk(16'hAAAA, BITS_ELEM'(IN+12), BITS_ELEM'(IN+13));
        c_ff  = mk(16'hFFFF, BITS_ELEM'(IN+0), BITS_ELEM'(IN+1));
        c_sel = mk(16'hFFFF, BITS_ELEM'(31), BITS_ELEM'(0));

        run(c_id, t_id, "identity", 32, 1'b0, '0);
        run(c_id, ~t_id, "inverted", 0, 1'b0, '0);
        run(c_ff, t_const, "constant", 16, 1'b0, '0);
        run(c_sel, t_sel, "selector_range", 32, 1'b0, '0);

        // Ignored mid-run start, then back-to-back start right after done.
        run(c_id, t_id, "ignored_start", 32, 1'b1, c_ff);
        run(c_ff, t_const, "back_to_back", 16, 1'b0, '0);

        for (int i = 0; i < 6; i++) begin
            for (int b = 0; b < CROM_W; b++) c_rnd[b] = 1'($urandom_range(0, 1));
            for (int b = 0; b < TGT_W; b++)  t_rnd[b] = 1'($urandom_range(0, 1));
            run(c_rnd, t_rnd, $sformatf("random%0d", i), -1, 1'b0, '0);
        end

        // Abort mid-run with reset; no done may follow without a new start.
        cromossomo = c_id; target = t_id; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 1; i < 40; i++) begin @(posedge clk); #1; end
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_fit", 32'(fitness), 32'd0);
        #2 rst_n = 1'b1;
        seen = 1'b0;
        n = 0;
        repeat (120) begin
            @(posedge clk); #1;
            if (done || busy) seen = 1'b1;
            n++;
        end
        check("abort_no_done", 32'(seen), 32'd0);
        run(c_id, t_id, "after_abort", 32, 1'b0, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fenotipo_fitness_serial.md
Name: fenotipo_fitness_serial

Overview:
- Sequential successor to the combinational phenotype decoder.
- Latches one chromosome: a ROW x COL grid of K-input LUT truth tables plus OUT output selectors.
- Sweeps all 2^IN input vectors, evaluating the grid one column per cycle, and compares each vector's outputs against a target truth table.
- Returns a match-count fitness to the genetic-algorithm controller, trading area for throughput on the serial evolution loop.

Parameters:
- IN, 4: primary inputs of the evolved circuit.
- OUT, 2: evolved circuit outputs.
- ROW, 4: LUT rows per column.
- COL, 4: LUT columns.
- K, 4: LUT inputs; truth table width TT = 2^K.
- BITS_ELEM, $clog2(IN+ROW*COL): output-selector width per output.
- BITS_MAT, TT*ROW*COL (derived): grid-description width.
- FIT_W, $clog2(OUT*2^IN+1) (derived): fitness width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to evaluate cromossomo against target.
- cromossomo  in  BITS_MAT+BITS_ELEM*OUT  chromosome; sampled only on accepted start.
- target  in  OUT*2^IN  expected outputs; bit v*OUT+k is output k for input vector v; sampled on accepted start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse; fitness valid from this cycle.
- fitness  out  FIT_W  number of matching output bits over all vectors.

Behaviour:
- Reset: all state to IDLE; busy=0, done=0, fitness=0; latched chromosome, target and counters cleared. Asynchronous; mid-run reset aborts with no done pulse.
- Chromosome slicing:
  - Descriptor[r][c] = cromossomo[TT*(COL*r+c) +: TT].
  - Selector k = cromossomo[BITS_MAT + BITS_ELEM*k +: BITS_ELEM].
- LUT function: out = desc[{a_{K-1},...,a_0}], where a_t is LUT input t.
- Fixed connectivity:
  - Column 0, row r: a_t = vector bit (r+t) mod IN.
  - Column c>0, row r: a_t = node[c-1][(r+t) mod ROW].
- Node index space: 0..IN-1 are primary inputs; IN + c*ROW + r is LUT (r,c). Selector values >= IN+ROW*COL yield constant 0.
- FSM states:
  - IDLE: start=1 latches chromosome and target, clears vec, col and acc, then goes to EVAL. start=0 stays in IDLE.
  - EVAL: computes column col into the node register (ROW bits per column, all columns retained). col==COL-1 goes to CMP; otherwise col++.
  - CMP: forms OUT outputs via the selectors and adds popcount(~(outs ^ target slice for vec)) to acc. If vec==2^IN-1, goes to DONE; otherwise vec++, col=0, back to EVAL.
  - DONE: fitness<=acc, done=1 for exactly this cycle, then IDLE.
- Latency: start accepted in cycle t gives done in cycle t+2^IN*(COL+1)+1; this is 81 with defaults.
- busy is high in EVAL, CMP and DONE; done is not asserted while busy is low.
- start while busy is ignored, and the latched operands are unaffected.
- start in the DONE cycle is ignored; start is accepted from IDLE in the following cycle.
- fitness holds its value until the next DONE; it does not clear on start.
- acc is width FIT_W and cannot overflow; the maximum value is OUT*2^IN.
- cromossomo and target may change freely after acceptance.

Decomposition:
- Shared package fenotipo_pkg holds:
  - Derived constants: TT, BITS_MAT, FIT_W, NODES=IN+ROW*COL.
  - The node-index function.
  - The state enum {IDLE, EVAL, CMP, DONE}.
- It is shared with the combinational decoder's parameter set.
- Sub-module lut_column: combinational; takes ROW descriptors and a K-wide input vector per row, produces ROW outputs. It is instantiated once and fed by a column mux selected by col.

Test Plan:
- Identity grid: all descriptors 0xAAAA, selectors {0:IN+12, 1:IN+13}, target equal to inputs bits 0/1 per vector -> done at cycle t+81, fitness=32.
- Same chromosome, target bitwise inverted -> fitness=0. Then constant grid, all descriptors 0xFFFF with selectors IN+0 and IN+1, target with output-0 bits=1 and output-1 bits=0 -> fitness=16.
- Selectors 31 and 0 (31 out of range -> constant 0; 0 -> input 0); target output0=0, output1=vector bit0 -> fitness=32.
- start pulsed again at cycle t+10 with different cromossomo -> ignored; single done at t+81 with the first chromosome's fitness. Back-to-back start at t+82 accepted.
- rst_n low at cycle t+40 -> busy=0, done=0, fitness=0 immediately. After release, no done pulse until a new start.
